mem_access_unit: RTL

- Memory-access stage that consumes execute-stage results: ALU result, store data, zero flag and branch target.
- Resolves branches, performs doubleword LDUR/STUR accesses to data memory over a req/ack handshake with variable latency, and presents results to writeback.
- Stalls the execute stage through ex_ready while an access is outstanding or writeback is back-pressured.

---
 rtl/mem_access_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Memory-access stage: branch resolution, doubleword LDUR/STUR over a req/ack port, writeback hand-off.
// Optional MEM_TIMEOUT_EN bounds the dmem wait to TIMEOUT_CYCLES and flags a fault on expiry.
module mem_access_unit #(
  parameter int WORD_W         = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [WORD_W-1:0] alu_result,
  input  logic [WORD_W-1:0] write_data,
  input  logic              zero,
  input  logic [WORD_W-1:0] branch_target,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              branch,
  input  logic              uncond_branch,
  input  logic              mem_to_reg,
  input  logic              reg_write,
  input  logic [4:0]        write_reg,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [WORD_W-1:0] dmem_addr,
  output logic [WORD_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [WORD_W-1:0] dmem_rdata,
  output logic              pc_src,
  output logic [WORD_W-1:0] pc_target,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [WORD_W-1:0] wb_data,
  output logic [4:0]        wb_reg,
  output logic              wb_reg_write,
  output logic              mem_err
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] WB_HOLD  = 2'd2;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0] state;
  logic       mem_to_reg_q;
  logic       load_write_q;
  logic       is_mem;
  logic       is_branch;
  logic       fault;
  logic       can_write;
  logic       timed_out;

  // Handshake outputs decode straight from state, so a reset withdraws dmem_req without waiting for a clock.
  assign ex_ready = (state == IDLE);
  assign dmem_req = (state == MEM_WAIT);
  assign wb_valid = (state == WB_HOLD);

  // NOTE: every variable assigned in always_comb gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    is_mem    = mem_read | mem_write;
    is_branch = branch | uncond_branch;
    fault     = is_mem && ((alu_result[2:0] != 3'b000) || (mem_read && mem_write));
    can_write = reg_write && (write_reg != 5'd31);
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  wait_cnt <= '0;
    else if (state != MEM_WAIT) wait_cnt <= '0;
    else if (!dmem_ack)         wait_cnt <= wait_cnt + 1'b1;
  end

  // Expires at the end of the TIMEOUT_CYCLES-th wait cycle; a coincident ack takes priority.
  assign timed_out = !dmem_ack && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timed_out = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      pc_src       <= 1'b0;
      pc_target    <= '0;
      wb_data      <= '0;
      wb_reg       <= '0;
      wb_reg_write <= 1'b0;
      mem_err      <= 1'b0;
      mem_to_reg_q <= 1'b0;
      load_write_q <= 1'b0;
    end else begin
      pc_src <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid) begin
            pc_src       <= uncond_branch | (branch & zero);
            pc_target    <= branch_target;
            wb_reg       <= write_reg;
            wb_data      <= alu_result;
            mem_to_reg_q <= mem_to_reg;
            load_write_q <= can_write && mem_read;
            if (is_mem && !fault) begin
              state      <= MEM_WAIT;
              dmem_we    <= mem_write;
              dmem_addr  <= alu_result;
              dmem_wdata <= write_data;
            end else begin
              state        <= WB_HOLD;
              mem_err      <= fault;
              wb_reg_write <= can_write && !is_mem && !is_branch;
            end
          end
        end
        MEM_WAIT: begin
          if (dmem_ack) begin
            state        <= WB_HOLD;
            dmem_we      <= 1'b0;
            wb_reg_write <= load_write_q;
            if (!dmem_we && mem_to_reg_q) wb_data <= dmem_rdata;
          end else if (timed_out) begin
            state        <= WB_HOLD;
            dmem_we      <= 1'b0;
            mem_err      <= 1'b1;
            wb_reg_write <= 1'b0;
          end
        end
        WB_HOLD: begin
          if (wb_ready) begin
            state        <= IDLE;
            mem_err      <= 1'b0;
            wb_reg_write <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
